// File: rtl/ball_motion_if.sv
// Signal bundle between a ball_motion instance and the game logic driving it.
interface ball_motion_if #(
  parameter int XW = 3,
  parameter int YW = 3
);
  logic          en;
  logic          serve;
  logic          endgame;
  logic          hit_l;
  logic          hit_r;
  logic [XW-1:0] x_pos;
  logic [YW-1:0] y_pos;
  logic          x_dir;
  logic          y_dir;
  logic          miss_l;
  logic          miss_r;
  logic          moving;

  modport master (
    output en, serve, endgame, hit_l, hit_r,
    input  x_pos, y_pos, x_dir, y_dir, miss_l, miss_r, moving
  );

  modport slave (
    input  en, serve, endgame, hit_l, hit_r,
    output x_pos, y_pos, x_dir, y_dir, miss_l, miss_r, moving
  );
endinterface

// File: rtl/ball_motion.sv
// Ball position/direction engine for a paddle game: serve, bounce, miss, freeze.
// Optional macro BALL_SPEEDUP_EN shortens the step period on every paddle hit.
module ball_motion #(
  parameter int WIDTH    = 8,
  parameter int HEIGHT   = 8,
  parameter int XW       = 3,
  parameter int YW       = 3,
  parameter int TICK_DIV = 1024,
  parameter int START_X  = 3,
  parameter int START_Y  = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ball_motion_if.slave  io_bus
);
  localparam int CW = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_MOVE = 2'd1, S_OVER = 2'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_period;
  logic [XW-1:0] r_x, w_x_nxt;
  logic [YW-1:0] r_y, w_y_nxt;
  logic          r_xd, r_yd, w_xd_nxt, w_yd_nxt;
  logic          r_miss_l, r_miss_r;
  logic          w_run, w_tick, w_at_r, w_at_l, w_y_edge;
  logic          w_miss_l, w_miss_r, w_hit;

  // endgame overrides every other input, so it also blocks a tick
  assign w_run    = io_bus.en && !io_bus.endgame;
  assign w_tick   = w_run && (r_state == S_MOVE) && (r_cnt == w_period - CW'(1));
  assign w_at_r   = !r_xd && (r_x == XW'(WIDTH - 1));
  assign w_at_l   =  r_xd && (r_x == '0);
  assign w_y_edge = r_yd ? (r_y == '0) : (r_y == YW'(HEIGHT - 1));
  assign w_miss_r = w_tick && w_at_r && !io_bus.hit_r;
  assign w_miss_l = w_tick && w_at_l && !io_bus.hit_l;
  assign w_hit    = w_tick && ((w_at_r && io_bus.hit_r) || (w_at_l && io_bus.hit_l));

  // a bounce (or miss) flips the direction; the step then follows the new direction
  always_comb begin
    w_xd_nxt = r_xd ^ (w_at_r | w_at_l);
    w_yd_nxt = r_yd ^ w_y_edge;
    w_x_nxt  = w_xd_nxt ? r_x - XW'(1) : r_x + XW'(1);
    w_y_nxt  = w_yd_nxt ? r_y - YW'(1) : r_y + YW'(1);
  end

`ifdef BALL_SPEEDUP_EN
  localparam int STEP  = TICK_DIV / 8;
  localparam int FLOOR = TICK_DIV / 4;
  logic [CW-1:0] r_period;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_period <= CW'(TICK_DIV);
    end else if (io_bus.endgame || w_miss_l || w_miss_r) begin
      r_period <= CW'(TICK_DIV);
    end else if (w_hit) begin
      r_period <= (r_period >= CW'(FLOOR + STEP)) ? r_period - CW'(STEP) : CW'(FLOOR);
    end
  end
  assign w_period = r_period;
`else
  assign w_period = CW'(TICK_DIV);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_SERVE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (io_bus.endgame) begin
      w_state_nxt = S_OVER;
    end else if (io_bus.en) begin
      case (r_state)
        S_SERVE: if (io_bus.serve)          w_state_nxt = S_MOVE;
        S_MOVE:  if (w_miss_l || w_miss_r)  w_state_nxt = S_SERVE;
        S_OVER:  if (io_bus.serve)          w_state_nxt = S_SERVE;
        default:                            w_state_nxt = S_SERVE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x      <= XW'(START_X);
      r_y      <= YW'(START_Y);
      r_xd     <= 1'b0;
      r_yd     <= 1'b0;
      r_cnt    <= '0;
      r_miss_l <= 1'b0;
      r_miss_r <= 1'b0;
    end else begin
      r_miss_l <= w_miss_l;
      r_miss_r <= w_miss_r;
      if (w_run) begin
        case (r_state)
          // counter is held at zero while serving, so MOVE always starts a full period
          S_SERVE: begin
            r_x   <= XW'(START_X);
            r_y   <= YW'(START_Y);
            r_cnt <= '0;
          end
          S_MOVE: begin
            if (w_tick) begin
              r_cnt <= '0;
              r_xd  <= w_xd_nxt;
              r_yd  <= w_yd_nxt;
              if (w_miss_l || w_miss_r) begin
                r_x <= XW'(START_X);
                r_y <= YW'(START_Y);
              end else begin
                r_x <= w_x_nxt;
                r_y <= w_y_nxt;
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
          S_OVER: begin
            if (io_bus.serve) begin
              r_x   <= XW'(START_X);
              r_y   <= YW'(START_Y);
              r_cnt <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign io_bus.x_pos  = r_x;
  assign io_bus.y_pos  = r_y;
  assign io_bus.x_dir  = r_xd;
  assign io_bus.y_dir  = r_yd;
  assign io_bus.miss_l = r_miss_l;
  assign io_bus.miss_r = r_miss_r;
  assign io_bus.moving = (r_state == S_MOVE);
endmodule

// File: tb/tb_ball_motion.sv
// Scenario bench for ball_motion with TICK_DIV=4 on an 8x8 field; a second
// instance served at (3,3) reaches the (7,7) corner.
module tb_ball_motion;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ball_motion_if #(.XW(3), .YW(3)) bus  ();
  ball_motion_if #(.XW(3), .YW(3)) bus2 ();

  ball_motion #(.WIDTH(8), .HEIGHT(8), .XW(3), .YW(3), .TICK_DIV(4),
                .START_X(3), .START_Y(4)) dut  (.clk(clk), .rst_n(rst_n), .io_bus(bus));
  ball_motion #(.WIDTH(8), .HEIGHT(8), .XW(3), .YW(3), .TICK_DIV(4),
                .START_X(3), .START_Y(3)) dut2 (.clk(clk), .rst_n(rst_n), .io_bus(bus2));

  typedef struct packed {
    logic [2:0] x;
    logic [2:0] y;
    logic xd, yd, ml, mr, mv;
  } snap_t;

  snap_t q[$];
  snap_t got, want;
  int vectors = 0;
  int miscompares = 0;

  function automatic snap_t mk(int x, int y, int xd, int yd, int ml, int mr, int mv);
    snap_t s;
    s.x = 3'(x); s.y = 3'(y); s.xd = 1'(xd); s.yd = 1'(yd);
    s.ml = 1'(ml); s.mr = 1'(mr); s.mv = 1'(mv);
    return s;
  endfunction

  function automatic snap_t snap1();
    return {bus.x_pos, bus.y_pos, bus.x_dir, bus.y_dir, bus.miss_l, bus.miss_r, bus.moving};
  endfunction

  function automatic snap_t snap2();
    return {bus2.x_pos, bus2.y_pos, bus2.x_dir, bus2.y_dir, bus2.miss_l, bus2.miss_r, bus2.moving};
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("(%0d,%0d) xd=%0d yd=%0d ml=%0d mr=%0d mv=%0d",
                     s.x, s.y, s.xd, s.yd, s.ml, s.mr, s.mv);
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.en = 0; bus.serve = 0; bus.endgame = 0; bus.hit_l = 0; bus.hit_r = 0;
    bus2.en = 0; bus2.serve = 0; bus2.endgame = 0; bus2.hit_l = 0; bus2.hit_r = 0;
    #12;
    q.push_back(mk(3, 4, 0, 0, 0, 0, 0));
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 3, 0, 0, 0, 0, 0));
    got = snap2(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset2: got %s want %s", fmt(got), fmt(want)); end
    @(negedge clk) rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_serve();
    bus.en = 1; bus.serve = 1;
    q.push_back(mk(3, 4, 0, 0, 0, 0, 1));
    step(1); bus.serve = 0;
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL serve_enter: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 4, 0, 0, 0, 0, 1));
    step(3);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL pre_tick: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(4, 5, 0, 0, 0, 0, 1));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL first_step: got %s want %s", fmt(got), fmt(want)); end
  endtask

  // top bounce, right-paddle return, bottom bounce, left-paddle return
  task automatic test_bounce();
    int ex  [11] = '{5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int ey  [11] = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int exd [11] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int eyd [11] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    bus.hit_l = 1; bus.hit_r = 1;
    for (int i = 0; i < 11; i++) begin
      q.push_back(mk(ex[i], ey[i], exd[i], eyd[i], 0, 0, 1));
      step(4);
      got = snap1(); want = q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL bounce_t%0d: got %s want %s", i + 2, fmt(got), fmt(want));
      end
    end
  endtask

  // hit_r is high except on the tick cycle itself, so only the tick sample may count
  task automatic test_miss_r();
    int ex  [6] = '{2, 3, 4, 5, 6, 7};
    int ey  [6] = '{3, 4, 5, 6, 7, 6};
    int eyd [6] = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      q.push_back(mk(ex[i], ey[i], 0, eyd[i], 0, 0, 1));
      step(4);
      got = snap1(); want = q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL approach_r%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    step(3); bus.hit_r = 0;
    q.push_back(mk(3, 4, 1, 1, 0, 1, 0));
    step(1); bus.hit_r = 1;
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL miss_r_pulse: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 4, 1, 1, 0, 0, 0));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL miss_r_clear: got %s want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_miss_l();
    bus.hit_l = 0; bus.serve = 1;
    q.push_back(mk(3, 4, 1, 1, 0, 0, 1));
    step(1); bus.serve = 0;
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL serve_dirs_kept: got %s want %s", fmt(got), fmt(want)); end
    for (int i = 0; i < 3; i++) begin
      q.push_back(mk(2 - i, 3 - i, 1, 1, 0, 0, 1));
      step(4);
      got = snap1(); want = q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL approach_l%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    q.push_back(mk(3, 4, 0, 1, 1, 0, 0));
    step(4);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL miss_l_pulse: got %s want %s", fmt(got), fmt(want)); end
    bus.en = 0; bus.serve = 1;
    q.push_back(mk(3, 4, 0, 1, 0, 0, 0));
    step(3);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_serve_ignored: got %s want %s", fmt(got), fmt(want)); end
    bus.serve = 0; bus.en = 1;
  endtask

  task automatic test_en_hold();
    bus.serve = 1;
    step(1); bus.serve = 0;
    step(2);
    bus.en = 0;
    q.push_back(mk(3, 4, 0, 1, 0, 0, 1));
    step(10);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL en0_hold: got %s want %s", fmt(got), fmt(want)); end
    bus.en = 1;
    q.push_back(mk(3, 4, 0, 1, 0, 0, 1));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL resume_partial: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(4, 3, 0, 1, 0, 0, 1));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL resume_tick: got %s want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_endgame();
    step(3);
    bus.endgame = 1; bus.serve = 1;
    q.push_back(mk(4, 3, 0, 1, 0, 0, 0));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL endgame_beats_tick: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(4, 3, 0, 1, 0, 0, 0));
    step(5);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL over_frozen: got %s want %s", fmt(got), fmt(want)); end
    bus.endgame = 0; bus.serve = 0;
    q.push_back(mk(4, 3, 0, 1, 0, 0, 0));
    step(2);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL over_wait: got %s want %s", fmt(got), fmt(want)); end
    bus.serve = 1;
    q.push_back(mk(3, 4, 0, 1, 0, 0, 0));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL over_exit: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 4, 0, 1, 0, 0, 1));
    step(1); bus.serve = 0;
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reserve: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 4, 0, 1, 0, 0, 1));
    step(3);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL no_stale_count: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(4, 3, 0, 1, 0, 0, 1));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL fresh_tick: got %s want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_reset_midmove();
    step(2);
    @(negedge clk) rst_n = 1'b0;
    #1;
    q.push_back(mk(3, 4, 0, 0, 0, 0, 0));
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL async_reset: got %s want %s", fmt(got), fmt(want)); end
    @(negedge clk) rst_n = 1'b1; bus.serve = 1;
    q.push_back(mk(3, 4, 0, 0, 0, 0, 1));
    step(1); bus.serve = 0;
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_reserve: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(3, 4, 0, 0, 0, 0, 1));
    step(3);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_no_stale: got %s want %s", fmt(got), fmt(want)); end
    q.push_back(mk(4, 5, 0, 0, 0, 0, 1));
    step(1);
    got = snap1(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL reset_first_tick: got %s want %s", fmt(got), fmt(want)); end
  endtask

  task automatic test_corner();
    bus2.en = 1; bus2.serve = 1; bus2.hit_r = 1;
    step(1); bus2.serve = 0;
    for (int i = 0; i < 4; i++) begin
      q.push_back(mk(4 + i, 4 + i, 0, 0, 0, 0, 1));
      step(4);
      got = snap2(); want = q.pop_front(); vectors++;
      if (got !== want) begin
        miscompares++; $display("FAIL diag%0d: got %s want %s", i, fmt(got), fmt(want));
      end
    end
    q.push_back(mk(6, 6, 1, 1, 0, 0, 1));
    step(4);
    got = snap2(); want = q.pop_front(); vectors++;
    if (got !== want) begin miscompares++; $display("FAIL corner_hit: got %s want %s", fmt(got), fmt(want)); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_bounce();
    test_miss_r();
    test_miss_l();
    test_en_hold();
    test_endgame();
    test_reset_midmove();
    test_corner();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ball_motion.md
BALL_MOTION -- requirements
Module: ball_motion

Interface
REQ-001 Parameter WIDTH, default 8, playfield columns (x range 0..WIDTH-1), min 4.
REQ-002 Parameter HEIGHT, default 8, playfield rows (y range 0..HEIGHT-1), min 4.
REQ-003 Parameter XW, default 3, x_pos width; YW, default 3, y_pos width; XW >= clog2(WIDTH), YW >= clog2(HEIGHT).
REQ-004 Parameter TICK_DIV, default 1024, clocks per move step, min 2; START_X default 3, START_Y default 4, serve position.
REQ-005 Ports: clk in 1 system clock; rst_n in 1 asynchronous active-low reset.
REQ-006 Ports: en in 1 run enable; serve in 1 serve request; endgame in 1 game-over freeze; hit_l in 1 left paddle covers ball row; hit_r in 1 right paddle covers ball row.
REQ-007 Ports: x_pos out XW; y_pos out YW; x_dir out 1 (0 = +x, 1 = -x); y_dir out 1 (0 = +y, 1 = -y); miss_l out 1; miss_r out 1; moving out 1.

Function
REQ-008 All state SHALL update on the rising edge of clk only.
REQ-009 States SHALL be SERVE, MOVE, OVER; moving SHALL be 1 only in MOVE.
REQ-010 Tick counter SHALL count 0..TICK_DIV-1 and wrap while en=1 and state=MOVE; tick asserts on the count==TICK_DIV-1 cycle; counter holds when en=0 and clears on entry to MOVE.
REQ-011 SERVE: x_pos=START_X, y_pos=START_Y held; serve=1 with en=1 SHALL go to MOVE next cycle, directions unchanged.
REQ-012 MOVE on tick, y axis: if y_dir=0 and y_pos=HEIGHT-1, or y_dir=1 and y_pos=0, flip y_dir and step y one cell opposite; else step y by one in y_dir.
REQ-013 MOVE on tick, x axis at right edge (x_dir=0, x_pos=WIDTH-1): hit_r=1 -> x_dir=1, x_pos=WIDTH-2; hit_r=0 -> miss_r pulse, go to SERVE, x_dir=1.
REQ-014 MOVE on tick, x axis at left edge (x_dir=1, x_pos=0): hit_l=1 -> x_dir=0, x_pos=1; hit_l=0 -> miss_l pulse, go to SERVE, x_dir=0.
REQ-015 Otherwise x SHALL step by one in x_dir; x and y evaluated independently in the same tick (corner hit flips both).
REQ-016 hit_l/hit_r SHALL be sampled only on the tick cycle.
REQ-017 miss_l/miss_r SHALL be single-cycle pulses, asserted the cycle after the missing tick; never both high.
REQ-018 endgame=1 SHALL force OVER from any state next cycle, freezing x_pos, y_pos, directions, counter; endgame beats serve and tick in the same cycle.
REQ-019 OVER SHALL exit to SERVE only when endgame=0 and serve=1, loading START_X/START_Y.
REQ-020 en=0 SHALL freeze all outputs and counters without changing state; serve ignored.

Reset
REQ-021 rst_n=0 SHALL asynchronously set state=SERVE, x_pos=START_X, y_pos=START_Y, x_dir=0, y_dir=0, tick counter=0, miss_l=miss_r=0, moving=0.
REQ-022 Reset mid-move SHALL discard any pending tick; first tick after re-serve occurs TICK_DIV cycles after MOVE entry.

Configuration
REQ-023 Macro BALL_SPEEDUP_EN defined: each paddle hit SHALL reduce effective tick period by TICK_DIV/8 (integer), floored at TICK_DIV/4; period restores to TICK_DIV on any miss, on OVER, on reset.
REQ-024 Macro BALL_SPEEDUP_EN undefined: tick period SHALL be fixed at TICK_DIV; no speed logic synthesised.

Verification
REQ-025 Reset, serve=1 en=1, TICK_DIV=4 -> MOVE; first step at 4 cycles: x_pos 3->4, y_pos 4->5.
REQ-026 Ball at y=7, y_dir=0, tick -> y_pos=6, y_dir=1; at (7,7) dirs 0/0 with hit_r=1 -> (6,6), both dirs 1.
REQ-027 x_pos=7, x_dir=0, hit_r=0 at tick -> miss_r one cycle high, state SERVE, position (3,4), x_dir=1.
REQ-028 endgame=1 with serve=1 mid-MOVE -> OVER, position frozen; endgame=0 then serve=1 -> SERVE at (3,4).
REQ-029 en=0 for 10 cycles mid-count -> counter and position hold; en=1 resumes with remaining count.
REQ-030 BALL_SPEEDUP_EN, TICK_DIV=64: successive hits give periods 56,48,...,16,16; miss -> 64.
